mac_sequencer: RTL

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mac_sequencer.sv
// mac_sequencer: sequences one MAC job (operand fetch, PE drain, result write, done pulse).
// Defining MAC_SEQUENCER_PERF_EN adds perf_cycles, the busy-cycle count of the last completed job.
module mac_sequencer #(
  parameter int A_ADDRWIDTH = 19,
  parameter int W_ADDRWIDTH = 15,
  parameter int O_ADDRWIDTH = 16,
  parameter int LEN_WIDTH   = 16,
  parameter int PE_LAT      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [A_ADDRWIDTH-1:0] a_base,
  input  logic [W_ADDRWIDTH-1:0] w_base,
  input  logic [O_ADDRWIDTH-1:0] o_dst,
  input  logic [LEN_WIDTH-1:0]   len,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   rd_en,
  output logic [A_ADDRWIDTH-1:0] a_addr,
  output logic [W_ADDRWIDTH-1:0] w_addr,
  output logic                   gate,
  output logic                   acc_clr,
  output logic                   o_we,
`ifdef MAC_SEQUENCER_PERF_EN
  output logic [31:0]            perf_cycles,
`endif
  output logic [O_ADDRWIDTH-1:0] o_addr
);
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;
  state_t st_q, st_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d, cnt_q, cnt_d;
  logic [O_ADDRWIDTH-1:0] o_dst_q, o_dst_d, o_addr_q, o_addr_d;
  logic [A_ADDRWIDTH-1:0] a_addr_q, a_addr_d;
  logic [W_ADDRWIDTH-1:0] w_addr_q, w_addr_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, rd_en_q, rd_en_d;
  logic gate_q, gate_d, acc_clr_q, acc_clr_d, o_we_q, o_we_d;
  always_comb begin
    st_d      = st_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    o_dst_d   = o_dst_q;
    o_addr_d  = o_addr_q;
    a_addr_d  = a_addr_q;
    w_addr_d  = w_addr_q;
    rd_en_d   = 1'b0;
    o_we_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    gate_d    = rd_en_q;
    acc_clr_d = rd_en_q && cnt_q == '0;
    case (st_q)
      IDLE: if (start) begin
        if (len != '0) begin
          st_d     = FETCH;
          len_d    = len;
          o_dst_d  = o_dst;
          a_addr_d = a_base;
          w_addr_d = w_base;
          cnt_d    = '0;
          rd_en_d  = 1'b1;
        end else err_d = 1'b1;
      end
      FETCH: if (cnt_q == len_q - LEN_WIDTH'(1)) begin
        st_d  = DRAIN;
        cnt_d = '0;
      end else begin
        cnt_d    = cnt_q + LEN_WIDTH'(1);
        rd_en_d  = 1'b1;
        a_addr_d = a_addr_q + A_ADDRWIDTH'(1);
        w_addr_d = w_addr_q + W_ADDRWIDTH'(1);
      end
      // DRAIN also covers the cycle carrying the last gate, hence PE_LAT+1 cycles
      DRAIN: if (cnt_q == LEN_WIDTH'(PE_LAT)) begin
        st_d     = WRITE;
        o_we_d   = 1'b1;
        o_addr_d = o_dst_q;
      end else cnt_d = cnt_q + LEN_WIDTH'(1);
      WRITE: begin
        st_d   = DONE;
        done_d = 1'b1;
      end
      default: st_d = IDLE;
    endcase
    busy_d = st_d != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      o_dst_q   <= '0;
      o_addr_q  <= '0;
      a_addr_q  <= '0;
      w_addr_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      gate_q    <= 1'b0;
      acc_clr_q <= 1'b0;
      o_we_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      o_dst_q   <= o_dst_d;
      o_addr_q  <= o_addr_d;
      a_addr_q  <= a_addr_d;
      w_addr_q  <= w_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_en_q   <= rd_en_d;
      gate_q    <= gate_d;
      acc_clr_q <= acc_clr_d;
      o_we_q    <= o_we_d;
    end
  end
`ifdef MAC_SEQUENCER_PERF_EN
  logic [31:0] cyc_q, cyc_d, perf_q, perf_d;
  always_comb begin
    cyc_d  = st_q == IDLE ? 32'd1 : (&cyc_q ? cyc_q : cyc_q + 32'd1);
    perf_d = done_d ? cyc_d : perf_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q  <= '0;
      perf_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      perf_q <= perf_d;
    end
  end
  assign perf_cycles = perf_q;
`endif
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rd_en   = rd_en_q;
  assign a_addr  = a_addr_q;
  assign w_addr  = w_addr_q;
  assign gate    = gate_q;
  assign acc_clr = acc_clr_q;
  assign o_we    = o_we_q;
  assign o_addr  = o_addr_q;
endmodule
